quad_nand_test_sequencer: RTL and testbench
===========================================

# quad_nand_test_sequencer

Self-test controller for the quad 2-input NAND emulator. On `start` it drives all 256 joint input vectors across the four gates and waits a programmable settle time after each one. It then compares the four outputs against ideal NAND behaviour and reports a per-gate fail mask and a pass flag. It sits between a bench or host command interface and the NAND IC instance, and owns that instance's input pins while busy.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 2: wait cycles between driving a vector and sampling `dut_y`. Legal range 1..15.

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: begin a run; sampled only in IDLE.
- `abort` in 1: cancel a run in progress.
- `busy` out 1: high from the cycle after `start` is accepted until DONE is left.
- `done` out 1: one-cycle pulse at the end of a completed run.
- `pass` out 1: high when the last completed run had `fail_mask==0`.
- `fail_mask` out 4: bit g is set if gate g mismatched on any vector.
- `dut_a`, `dut_b`, `dut_c`, `dut_d` out 2 each: input pairs of gates 0..3.
- `dut_y` in 4: outputs of the NAND IC, gate g on bit g.
- `first_fail_vec` out 8 (only with macro): vector index of the first mismatch.
- `first_fail_valid` out 1 (only with macro): `first_fail_vec` holds a captured value.

## Operation
- States: IDLE, DRIVE, SETTLE, CHECK, DONE.
- 8-bit vector counter `v`. Pin mapping:
  - `dut_a = v[1:0]`
  - `dut_b = v[3:2]`
  - `dut_c = v[5:4]`
  - `dut_d = v[7:6]`
- Expected output: `exp[g] = ~(v[2g] & v[2g+1])`.
- IDLE → DRIVE on `start`. This transition clears `v`, `fail_mask`, `pass` and the first-fail capture.
- DRIVE: pins are registered from `v`, then the state moves to SETTLE with the settle counter cleared.
- SETTLE: waits `SETTLE_CYCLES` cycles, then moves to CHECK.
- CHECK: `fail_mask <= fail_mask | (dut_y ^ exp)`.
  - If `v==255`, go to DONE.
  - Otherwise increment `v` and go to DRIVE.
- A mismatch does not stop the run; all 256 vectors are always applied.
- DONE: `done=1` for one cycle, `pass <= (fail_mask==0)` (with the final CHECK update included), then IDLE.
- In IDLE, the dut pins are driven to 0.
- `fail_mask` and `pass` hold their values until the next accepted `start`.
- `start` while busy is ignored; no queuing.
- `abort` in DRIVE, SETTLE or CHECK:
  - Next state is IDLE.
  - Pins return to 0.
  - `fail_mask` is cleared and `pass=0`.
  - No `done` pulse.
- `abort` in IDLE or DONE has no effect.
- `abort` and `start` together in IDLE: `abort` wins and `start` is ignored.
- `rst` mid-run behaves like reset at power-up; no partial results are kept.

## Timing
- Reset values: state IDLE, `busy=0`, `done=0`, `pass=0`, `fail_mask=0`, all dut pins 0, `v=0`, `first_fail_vec=0`, `first_fail_valid=0`.
- Each vector takes `SETTLE_CYCLES+2` cycles: DRIVE 1, SETTLE S, CHECK 1.
- `dut_y` is sampled exactly S+1 cycles after the pins change.
- Let the `start`-sampling edge be edge 0. `busy` rises after edge 0.
  - `done` is high in the cycle after edge 256·(S+2). That is edge 1024 for S=2.
  - `busy` falls on the edge that ends the DONE cycle.
- All outputs are registered. `dut_y` has no combinational path to any output.

## Configuration
- `QNT_FIRST_FAIL_EN` defined:
  - Adds `first_fail_vec` and `first_fail_valid`.
  - On the first CHECK with any mismatch in a run, latches `v` and sets valid.
  - Later mismatches do not overwrite the capture.
  - The capture is cleared on accepted `start`, on `abort` and on `rst`.
- Not defined: those ports and their registers are absent. All other behaviour is identical.

## Test plan
- Ideal NAND model, S=2, start pulse:
  - `done` one cycle after edge 1024.
  - `pass=1`, `fail_mask=4'b0000`.
  - Pins return to 0.
- Gate 2 output stuck at 1:
  - `fail_mask=4'b0100`, `pass=0`.
  - With macro: `first_fail_vec=8'h30`, `first_fail_valid=1`.
- Gate 0 output stuck at 0:
  - `fail_mask=4'b0001`.
  - With macro: `first_fail_vec=8'h00`.
- `abort` at edge 500:
  - Next cycle `busy=0`, pins=0, `fail_mask=0`.
  - No `done` within the next 2000 cycles.
- `start` reasserted at edge 100 of a run: ignored, `done` still after edge 1024. Then `rst` at edge 300 of a new run: all outputs return to their reset values on the next cycle.
- S=1 with an ideal model: `done` after edge 768, `pass=1`. Also sweep the pins cycle by cycle to confirm the mapping, e.g. `v=8'hB4` drives `dut_d=2'b10`, `dut_c=2'b11`, `dut_b=2'b01`, `dut_a=2'b00`.

Source files
------------

// File: rtl/quad_nand_test_sequencer.sv
// Self-test sequencer for the quad 2-input NAND emulator: walks all 256 joint input
// vectors, checks dut_y after a settle delay. Define QNT_FIRST_FAIL_EN to add first-fail capture.
module quad_nand_test_sequencer #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_mask,
  output logic [1:0] dut_a,
  output logic [1:0] dut_b,
  output logic [1:0] dut_c,
  output logic [1:0] dut_d,
  input  logic [3:0] dut_y
`ifdef QNT_FIRST_FAIL_EN
  ,
  output logic [7:0] first_fail_vec,
  output logic       first_fail_valid
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRIVE  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_CHECK  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  function automatic logic [3:0] nand_expect(input logic [7:0] vec);
    logic [3:0] e;
    for (int g = 0; g < 4; g++) begin
      e[g] = ~(vec[2*g] & vec[2*g+1]);
    end
    return e;
  endfunction

  state_t     state_q, state_d;
  logic [7:0] v_q, v_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] fail_mask_q, fail_mask_d;
  logic       pass_q, pass_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [7:0] pins_q, pins_d;
  logic [3:0] mismatch_s;
`ifdef QNT_FIRST_FAIL_EN
  logic [7:0] ff_vec_q, ff_vec_d;
  logic       ff_valid_q, ff_valid_d;
`endif

  assign mismatch_s = dut_y ^ nand_expect(v_q);

  // Next-state and registered-output computation
  always_comb begin
    state_d     = state_q;
    v_d         = v_q;
    cnt_d       = cnt_q;
    fail_mask_d = fail_mask_q;
    pass_d      = pass_q;
    pins_d      = pins_q;
    done_d      = 1'b0;
`ifdef QNT_FIRST_FAIL_EN
    ff_vec_d    = ff_vec_q;
    ff_valid_d  = ff_valid_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d     = ST_DRIVE;
          v_d         = 8'h00;
          fail_mask_d = 4'b0000;
          pass_d      = 1'b0;
`ifdef QNT_FIRST_FAIL_EN
          ff_vec_d    = 8'h00;
          ff_valid_d  = 1'b0;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DRIVE: begin
        pins_d  = v_q;
        cnt_d   = 4'd0;
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = ST_CHECK;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_CHECK: begin
        fail_mask_d = fail_mask_q | mismatch_s;
`ifdef QNT_FIRST_FAIL_EN
        // Only the first mismatching vector of a run is kept.
        if ((mismatch_s != 4'b0000) && !ff_valid_q) begin
          ff_vec_d   = v_q;
          ff_valid_d = 1'b1;
        end else begin
          ff_vec_d   = ff_vec_q;
        end
`endif
        if (v_q == 8'hFF) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          pass_d  = (fail_mask_d == 4'b0000);
        end else begin
          v_d     = v_q + 8'd1;
          state_d = ST_DRIVE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (abort && (state_q inside {ST_DRIVE, ST_SETTLE, ST_CHECK})) begin
      state_d     = ST_IDLE;
      fail_mask_d = 4'b0000;
      pass_d      = 1'b0;
      done_d      = 1'b0;
`ifdef QNT_FIRST_FAIL_EN
      ff_vec_d    = 8'h00;
      ff_valid_d  = 1'b0;
`endif
    end else begin
      done_d = done_d;
    end

    // The IC's pins are released to 0 whenever the sequencer goes idle.
    if (state_d == ST_IDLE) begin
      pins_d = 8'h00;
    end else begin
      pins_d = pins_d;
    end
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      v_q         <= 8'h00;
      cnt_q       <= 4'd0;
      fail_mask_q <= 4'b0000;
      pass_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pins_q      <= 8'h00;
`ifdef QNT_FIRST_FAIL_EN
      ff_vec_q    <= 8'h00;
      ff_valid_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      v_q         <= v_d;
      cnt_q       <= cnt_d;
      fail_mask_q <= fail_mask_d;
      pass_q      <= pass_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pins_q      <= pins_d;
`ifdef QNT_FIRST_FAIL_EN
      ff_vec_q    <= ff_vec_d;
      ff_valid_q  <= ff_valid_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail_mask = fail_mask_q;
  assign dut_a     = pins_q[1:0];
  assign dut_b     = pins_q[3:2];
  assign dut_c     = pins_q[5:4];
  assign dut_d     = pins_q[7:6];
`ifdef QNT_FIRST_FAIL_EN
  assign first_fail_vec   = ff_vec_q;
  assign first_fail_valid = ff_valid_q;
`endif

endmodule

// File: tb/tb_quad_nand_test_sequencer.sv
// Scoreboard bench for quad_nand_test_sequencer: two instances (S=2, S=1) driving a
// fault-injectable NAND IC model; expected results come from a vector-level reference model.
module tb_quad_nand_test_sequencer;

  localparam int S0 = 2;
  localparam int S1 = 1;

  typedef struct {
    int         inst;
    int         done_cyc;
    logic [3:0] fm;
    logic       pass;
    logic [7:0] ffv;
    logic       ffok;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0] rst_r, start_r, abort_r;
  logic [3:0] f_en [2];
  logic [3:0] f_val [2];
  logic [1:0] busy_w, done_w, pass_w;
  logic [3:0] fm_w [2];
  logic [1:0] a_w [2];
  logic [1:0] b_w [2];
  logic [1:0] c_w [2];
  logic [1:0] d_w [2];
  logic [7:0] pins_w [2];
  logic [3:0] y_w [2];
`ifdef QNT_FIRST_FAIL_EN
  logic [7:0] ffv_w [2];
  logic [1:0] ffok_w;
`endif

  int n_vec = 0;
  int n_err = 0;
  exp_t sb_q [$];
  logic [1:0] post_pend = 2'b00;
  exp_t post_e [2];

  // NAND IC model: gate g optionally stuck at f_val[g].
  function automatic logic [3:0] ic(input logic [7:0] p, input logic [3:0] en, input logic [3:0] val);
    logic [3:0] y;
    for (int g = 0; g < 4; g++) y[g] = en[g] ? val[g] : ~(p[2*g] & p[2*g+1]);
    return y;
  endfunction

  for (genvar i = 0; i < 2; i++) begin : g_wire
    assign pins_w[i] = {d_w[i], c_w[i], b_w[i], a_w[i]};
    assign y_w[i]    = ic(pins_w[i], f_en[i], f_val[i]);
  end

  quad_nand_test_sequencer #(.SETTLE_CYCLES(S0)) u_s2 (
    .clk(clk), .rst(rst_r[0]), .start(start_r[0]), .abort(abort_r[0]),
    .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]), .fail_mask(fm_w[0]),
    .dut_a(a_w[0]), .dut_b(b_w[0]), .dut_c(c_w[0]), .dut_d(d_w[0]), .dut_y(y_w[0])
`ifdef QNT_FIRST_FAIL_EN
    , .first_fail_vec(ffv_w[0]), .first_fail_valid(ffok_w[0])
`endif
  );

  quad_nand_test_sequencer #(.SETTLE_CYCLES(S1)) u_s1 (
    .clk(clk), .rst(rst_r[1]), .start(start_r[1]), .abort(abort_r[1]),
    .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]), .fail_mask(fm_w[1]),
    .dut_a(a_w[1]), .dut_b(b_w[1]), .dut_c(c_w[1]), .dut_d(d_w[1]), .dut_y(y_w[1])
`ifdef QNT_FIRST_FAIL_EN
    , .first_fail_vec(ffv_w[1]), .first_fail_valid(ffok_w[1])
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Reference: walk vector indices, compare each gate's faulty output with ideal NAND.
  function automatic exp_t ref_run(input logic [3:0] en, input logic [3:0] val);
    exp_t e;
    int pair, ideal, act;
    e.fm = 4'b0000; e.ffv = 8'h00; e.ffok = 1'b0;
    e.inst = 0; e.done_cyc = 0;
    for (int v = 0; v < 256; v++) begin
      for (int g = 0; g < 4; g++) begin
        pair  = (v >> (2 * g)) % 4;
        ideal = (pair == 3) ? 0 : 1;
        act   = en[g] ? int'(val[g]) : ideal;
        if (act != ideal) begin
          e.fm[g] = 1'b1;
          if (!e.ffok) begin
            e.ffv  = 8'(v);
            e.ffok = 1'b1;
          end
        end
      end
    end
    e.pass = (e.fm == 4'b0000);
    return e;
  endfunction

  task automatic chk_reset(input int i);
    chk("rst_busy", 32'(busy_w[i]), 32'd0);
    chk("rst_done", 32'(done_w[i]), 32'd0);
    chk("rst_pass", 32'(pass_w[i]), 32'd0);
    chk("rst_fail_mask", 32'(fm_w[i]), 32'd0);
    chk("rst_pins", 32'(pins_w[i]), 32'd0);
`ifdef QNT_FIRST_FAIL_EN
    chk("rst_ffv", 32'(ffv_w[i]), 32'd0);
    chk("rst_ffok", 32'(ffok_w[i]), 32'd0);
`endif
  endtask

  // Monitor: pops the scoreboard on every done pulse, then checks the idle cycle after it.
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      if (post_pend[i]) begin
        post_pend[i] = 1'b0;
        chk("busy_after_done", 32'(busy_w[i]), 32'd0);
        chk("pins_after_done", 32'(pins_w[i]), 32'd0);
        chk("fail_mask_held", 32'(fm_w[i]), 32'(post_e[i].fm));
        chk("pass_held", 32'(pass_w[i]), 32'(post_e[i].pass));
      end
      if (done_w[i]) begin
        if (sb_q.size() == 0 || sb_q[0].inst != i) begin
          chk("unexpected_done", 32'(done_w[i]), 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk("done_cycle", 32'(cyc), 32'(e.done_cyc));
          chk("fail_mask", 32'(fm_w[i]), 32'(e.fm));
          chk("pass", 32'(pass_w[i]), 32'(e.pass));
`ifdef QNT_FIRST_FAIL_EN
          chk("first_fail_vec", 32'(ffv_w[i]), 32'(e.ffv));
          chk("first_fail_valid", 32'(ffok_w[i]), 32'(e.ffok));
`endif
          post_e[i]    = e;
          post_pend[i] = 1'b1;
        end
      end
    end
  end

  // One run: start, optional extra start / abort / rst at edge N after start, pin sweep each cycle.
  task automatic run(input int i, input logic [3:0] en, input logic [3:0] val,
                     input int xstart, input int abort_at, input int rst_at);
    int s, total, e0;
    logic [7:0] pexp;
    exp_t e;
    s = (i == 0) ? S0 : S1;
    total = 256 * (s + 2);
    f_en[i] = en;
    f_val[i] = val;
    e = ref_run(en, val);
    e.inst = i;
    @(negedge clk);
    start_r[i] = 1'b1;
    @(negedge clk);
    start_r[i] = 1'b0;
    e0 = cyc;
    e.done_cyc = e0 + total;
    sb_q.push_back(e);
    chk("busy_rise", 32'(busy_w[i]), 32'd1);
    for (int k = 0; k <= total + 2; k++) begin
      if (k > 0) @(negedge clk);
      if (abort_at > 0 && k == abort_at) begin
        abort_r[i] = 1'b0;
        void'(sb_q.pop_back());
        chk("abort_busy", 32'(busy_w[i]), 32'd0);
        chk("abort_pins", 32'(pins_w[i]), 32'd0);
        chk("abort_fail_mask", 32'(fm_w[i]), 32'd0);
        chk("abort_pass", 32'(pass_w[i]), 32'd0);
`ifdef QNT_FIRST_FAIL_EN
        chk("abort_ffok", 32'(ffok_w[i]), 32'd0);
`endif
        break;
      end
      if (rst_at > 0 && k == rst_at) begin
        rst_r[i] = 1'b0;
        void'(sb_q.pop_back());
        chk_reset(i);
        break;
      end
      pexp = (k >= 1 && k <= total) ? 8'((k - 1) / (s + 2)) : 8'h00;
      chk("pins", 32'(pins_w[i]), 32'(pexp));
      start_r[i] = (k == xstart - 1);
      abort_r[i] = (k == abort_at - 1);
      rst_r[i]   = (k == rst_at - 1);
    end
    start_r[i] = 1'b0;
  endtask

  initial begin
    int nd;
    logic [3:0] ren, rval;
    rst_r = 2'b11; start_r = 2'b00; abort_r = 2'b00;
    f_en[0] = 4'h0; f_en[1] = 4'h0; f_val[0] = 4'h0; f_val[1] = 4'h0;
    repeat (3) @(negedge clk);
    rst_r = 2'b00;
    chk_reset(0);
    chk_reset(1);

    run(0, 4'b0000, 4'b0000, 0, 0, 0);      // ideal, S=2
    run(0, 4'b0100, 4'b0100, 0, 0, 0);      // gate 2 stuck at 1
    run(0, 4'b0001, 4'b0000, 0, 0, 0);      // gate 0 stuck at 0
    run(0, 4'b0100, 4'b0100, 0, 500, 0);    // abort at edge 500
    nd = 0;
    repeat (2000) begin
      @(negedge clk);
      if (done_w[0]) nd++;
    end
    chk("no_done_after_abort", 32'(nd), 32'd0);
    run(0, 4'b0000, 4'b0000, 100, 0, 0);    // start re-asserted mid-run
    run(0, 4'b1000, 4'b1000, 0, 0, 300);    // rst at edge 300

    // abort together with start in IDLE: nothing starts
    @(negedge clk);
    start_r[0] = 1'b1; abort_r[0] = 1'b1;
    @(negedge clk);
    start_r[0] = 1'b0; abort_r[0] = 1'b0;
    chk("idle_abort_start_busy", 32'(busy_w[0]), 32'd0);
    chk("idle_abort_start_pins", 32'(pins_w[0]), 32'd0);

    run(1, 4'b0000, 4'b0000, 0, 0, 0);      // ideal, S=1, full pin sweep
    for (int r = 0; r < 4; r++) begin
      ren  = 4'($urandom);
      rval = 4'($urandom);
      run(1, ren, rval, int'($urandom_range(1, 700)), 0, 0);
    end

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
